mips_run_ctrl: RTL and testbench
================================

# mips_run_ctrl

Synthesizable run controller for the single-cycle MIPS core: gates the core via a clock enable, executes from reset until the PC reaches a parametrised halt address, and supports N hardware breakpoints, single-step and resume. Sits beside `mips_top`, between board/bench controls and the core. Replaces the bench-only "tick until PC hits an address" loop with hardware that also counts executed instructions.

## Interface
- `PC_W`, 32, PC width
- `CNT_W`, 32, instruction counter width
- `NUM_BP`, 2, breakpoint channels (1..8)
- `HALT_ADDR`, 32'h48, PC value that ends a run
- `TIMEOUT`, 1000, instruction limit (used only with `RUN_CTRL_TIMEOUT_EN`)

- `clk` in 1: system clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle pulse; resets core and begins a run
- `cont` in 1: one-cycle pulse; resume from PAUSE
- `step` in 1: one-cycle pulse; execute one instruction from PAUSE
- `pc_current` in PC_W: core PC
- `bp_addr` in NUM_BP*PC_W: breakpoint addresses, channel i at [i*PC_W +: PC_W]
- `bp_en` in NUM_BP: per-channel enable
- `cpu_en` out 1: core clock enable (combinational)
- `cpu_rst` out 1: core reset
- `busy` out 1: state is RESET, RUN or STEP
- `done` out 1: halt address reached
- `bp_hit` out NUM_BP: latched channel(s) that caused the pause
- `cycle_cnt` out CNT_W: instructions executed this run
- `timeout` out 1: instruction limit exceeded

## Operation
- States: IDLE, RESET, RUN, STEP, PAUSE, HALT, FAULT.
- IDLE/HALT/PAUSE/FAULT + `start`: go to RESET, clear `cycle_cnt`, `bp_hit`, `done`, `timeout`.
- RESET: `cpu_rst`=1 for exactly 2 cycles, then RUN.
- RUN: `cpu_en` = 1 unless a stop condition holds on the current `pc_current`, checked in this order:
  - `pc_current`==HALT_ADDR: go to HALT, set `done`.
  - (macro) `cycle_cnt`==TIMEOUT: go to FAULT, set `timeout`.
  - any enabled channel matches: go to PAUSE, latch the matching bits into `bp_hit`.
- A stop condition drops `cpu_en` in the same cycle, so the instruction at the stop PC is not executed.
- PAUSE + `cont`: go to RUN with the breakpoint check suppressed for the first RUN cycle. Halt and timeout checks stay active. `bp_hit` clears.
- PAUSE + `step`: go to STEP. `cpu_en`=1 for exactly one cycle, then back to PAUSE.
- PAUSE with `pc_current`==HALT_ADDR: go to HALT.
- Input priority when pulses coincide: `start` > `cont` > `step`. Pulses outside their valid states are ignored.
- `cycle_cnt` increments on every edge with `cpu_en`=1 and saturates at all-ones.
- Breakpoints and halt use equality compare on all PC_W bits.

## Timing
- Reset values: `cpu_en`=0, `cpu_rst`=1 (asserted directly by `rst`), `busy`=0, `done`=0, `bp_hit`=0, `cycle_cnt`=0, `timeout`=0. State is IDLE.
- `rst` mid-run aborts immediately. No state survives.
- `start` at edge k: `cpu_rst` high during cycles k+1 and k+2. First `cpu_en` in cycle k+3.
- `done`, `bp_hit` and `timeout` are registered and valid the cycle after the stop is detected. They hold until the next `start` (`bp_hit` also clears on `cont`).

## Configuration
- `RUN_CTRL_TIMEOUT_EN` defined: timeout check and FAULT state are present. Only `start` (or `rst`) leaves FAULT.
- Not defined: no timeout logic, `timeout` tied 0, FAULT unreachable, runs are unbounded, `cycle_cnt` saturates.

## Test plan
Bench core model: PC resets to 0 on `cpu_rst` and adds 4 per `cpu_en` cycle.
- Reset, then `start`, no breakpoints → `done`=1, `pc_current`=0x48, `cycle_cnt`=18, `cpu_en`=0 thereafter.
- `bp_addr[0]`=0x10 enabled, `start` → PAUSE with `bp_hit`=2'b01, `cycle_cnt`=4. `step` → PC 0x14, `cycle_cnt`=5. `cont` → `done`, `cycle_cnt`=18.
- Breakpoint at 0x10: `cont` while paused at 0x10 → no re-trigger, PC advances to 0x14 next cycle.
- Both channels at 0x48, `start` → HALT, `done`=1, `bp_hit`=0 (halt wins).
- `RUN_CTRL_TIMEOUT_EN` defined, TIMEOUT=10, HALT_ADDR unreachable → FAULT, `timeout`=1, `cycle_cnt`=10. Then `start` → new run with `timeout`=0.
- `rst` pulsed at `cycle_cnt`=7 → all outputs at reset values next cycle, `cpu_rst`=1.

Source files
------------

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: clock-enable gating, halt address,
// hardware breakpoints, single-step/resume. Optional instruction limit: RUN_CTRL_TIMEOUT_EN.
module mips_run_ctrl #(
    parameter int              PC_W      = 32,
    parameter int              CNT_W     = 32,
    parameter int              NUM_BP    = 2,
    parameter logic [PC_W-1:0] HALT_ADDR = 32'h48,
    parameter int              TIMEOUT   = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cont,
    input  logic                   step,
    input  logic [PC_W-1:0]        pc_current,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_en,
    output logic                   cpu_en,
    output logic                   cpu_rst,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_BP-1:0]      bp_hit,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic                   timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_PAUSE = 3'd4,
        S_HALT  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              rst_cnt;
    logic              skip_bp;
    logic              halt_hit;
    logic              to_hit;
    logic              bp_stop;
    logic              start_acc;
    logic [NUM_BP-1:0] bp_match;

    assign halt_hit = (pc_current == HALT_ADDR);

`ifdef RUN_CTRL_TIMEOUT_EN
    assign to_hit = (cycle_cnt == CNT_W'(TIMEOUT));
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT == 0);
    assign to_hit         = 1'b0;
`endif

    // Per-channel breakpoint compare on the full PC width
    always_comb begin
        bp_match = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            bp_match[i] = bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc_current);
        end
    end

    // First RUN cycle after a resume ignores the breakpoint it paused on
    assign bp_stop   = (|bp_match) && !skip_bp;
    assign start_acc = start && (state == S_IDLE || state == S_HALT ||
                                 state == S_PAUSE || state == S_FAULT);
    assign cpu_rst   = rst || (state == S_RESET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_HALT, S_FAULT: begin
                if (start) next_state = S_RESET;
                else       next_state = state;
            end
            S_RESET: begin
                if (rst_cnt) next_state = S_RUN;
                else         next_state = S_RESET;
            end
            S_RUN: begin
                if (halt_hit)     next_state = S_HALT;
                else if (to_hit)  next_state = S_FAULT;
                else if (bp_stop) next_state = S_PAUSE;
                else              next_state = S_RUN;
            end
            S_STEP: next_state = S_PAUSE;
            S_PAUSE: begin
                if (start)         next_state = S_RESET;
                else if (halt_hit) next_state = S_HALT;
                else if (cont)     next_state = S_RUN;
                else if (step)     next_state = S_STEP;
                else               next_state = S_PAUSE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_en = 1'b0;
        busy   = 1'b0;
        case (state)
            S_RESET: busy = 1'b1;
            S_RUN: begin
                busy   = 1'b1;
                cpu_en = !(halt_hit || to_hit || bp_stop);
            end
            S_STEP: begin
                busy   = 1'b1;
                cpu_en = 1'b1;
            end
            default: begin
                busy   = 1'b0;
                cpu_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            bp_hit    <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            rst_cnt   <= 1'b0;
            skip_bp   <= 1'b0;
        end else if (start_acc) begin
            cycle_cnt <= '0;
            bp_hit    <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            rst_cnt   <= 1'b0;
            skip_bp   <= 1'b0;
        end else begin
            if (cpu_en && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (state == S_RESET) rst_cnt <= 1'b1;
            if (next_state == S_HALT && state != S_HALT) done <= 1'b1;
`ifdef RUN_CTRL_TIMEOUT_EN
            if (next_state == S_FAULT && state != S_FAULT) timeout <= 1'b1;
`endif
            if (state == S_RUN && next_state == S_PAUSE) bp_hit <= bp_match;
            if (state == S_PAUSE && next_state == S_RUN) begin
                bp_hit  <= '0;
                skip_bp <= 1'b1;
            end else if (state == S_RUN) begin
                skip_bp <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: a PC+4 core model plus a run-outcome reference
// model that predicts where each run stops from the halt/breakpoint/limit rules.
module tb_mips_run_ctrl;

    localparam logic [31:0] HALT = 32'h48;
    localparam int          TMO  = 10;

    logic        clk = 1'b0;
    logic        rst, start, cont, step;
    logic [31:0] core_pc;
    logic [31:0] bp0, bp1;
    logic [1:0]  en;
    logic        cpu_en, cpu_rst, busy, done, timeout;
    logic [1:0]  bp_hit;
    logic [31:0] cycle_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    int          exp_n;
    logic        exp_done, exp_to;
    logic [1:0]  exp_bp;

    mips_run_ctrl #(.PC_W(32), .CNT_W(32), .NUM_BP(2), .HALT_ADDR(HALT), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .step(step),
        .pc_current(core_pc), .bp_addr({bp1, bp0}), .bp_en(en),
        .cpu_en(cpu_en), .cpu_rst(cpu_rst), .busy(busy), .done(done),
        .bp_hit(bp_hit), .cycle_cnt(cycle_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Core model: PC clears on reset, advances one word per enabled cycle
    always @(posedge clk) begin
        if (cpu_rst)     core_pc <= 32'h0;
        else if (cpu_en) core_pc <= core_pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk instruction count n (PC = 4n) and return the first stop reason
    task automatic model_run(input int n0, input bit skip);
        logic [31:0] pc;
        logic [1:0]  h;
        for (int n = n0; n < 64; n++) begin
            pc = 32'(n * 4);
            if (pc == HALT) begin exp_n = n; exp_done = 1'b1; return; end
`ifdef RUN_CTRL_TIMEOUT_EN
            if (n == TMO) begin exp_n = n; exp_to = 1'b1; return; end
`endif
            h = {en[1] && (bp1 == pc), en[0] && (bp0 == pc)};
            if (h != 2'b00 && !(skip && n == n0)) begin exp_n = n; exp_bp = h; return; end
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 0)      start = 1'b1;
        else if (which == 1) cont  = 1'b1;
        else                 step  = 1'b1;
        @(negedge clk);
        start = 1'b0; cont = 1'b0; step = 1'b0;
    endtask

    task automatic settle_check(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk({tag, "_settle"}, busy, 1'b0);
        @(negedge clk);
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_timeout"}, timeout, exp_to);
        chk({tag, "_bp_hit"}, bp_hit, exp_bp);
        chk({tag, "_cnt"}, cycle_cnt, 32'(exp_n));
        chk({tag, "_pc"}, core_pc, 32'(exp_n * 4));
        chk({tag, "_cpu_en"}, cpu_en, 1'b0);
    endtask

    task automatic do_start(input string tag);
        pulse(0);
        exp_done = 1'b0; exp_to = 1'b0; exp_bp = 2'b00;
        model_run(0, 1'b0);
        chk({tag, "_rst_k1"}, cpu_rst, 1'b1);
        chk({tag, "_busy_k1"}, busy, 1'b1);
        chk({tag, "_to_clr"}, timeout, 1'b0);
        chk({tag, "_cnt_clr"}, cycle_cnt, 32'h0);
        @(negedge clk);
        chk({tag, "_rst_k2"}, cpu_rst, 1'b1);
        chk({tag, "_en_k2"}, cpu_en, 1'b0);
        @(negedge clk);
        chk({tag, "_rst_k3"}, cpu_rst, 1'b0);
        chk({tag, "_en_k3"}, cpu_en, exp_n != 0);
        settle_check(tag);
    endtask

    task automatic do_cont(input string tag);
        pulse(1);
        exp_bp = 2'b00;
        model_run(exp_n, 1'b1);
        settle_check(tag);
    endtask

    task automatic do_step(input string tag);
        pulse(2);
        exp_n = exp_n + 1;
        if (32'(exp_n * 4) == HALT) exp_done = 1'b1;
        settle_check(tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cont = 1'b0; step = 1'b0;
        bp0 = 32'h0; bp1 = 32'h0; en = 2'b00;
        repeat (2) @(negedge clk);
        chk("reset_cpu_rst", cpu_rst, 1'b1);
        chk("reset_cpu_en", cpu_en, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_bp_hit", bp_hit, 2'b00);
        chk("reset_cnt", cycle_cnt, 32'h0);
        chk("reset_timeout", timeout, 1'b0);
        rst = 1'b0;

        // Plain run to halt (or to the limit when enabled)
        do_start("run");
        chk("run_idle_after", cpu_en, 1'b0);

        // Breakpoint at 0x10, step, then resume
        bp0 = 32'h10; en = 2'b01;
        do_start("bp");
        do_step("bp_step");
        do_cont("bp_cont");

        // Resume from a breakpoint must not re-trigger on the same PC
        do_start("nort");
        pulse(1);
        exp_bp = 2'b00;
        chk("nort_cpu_en", cpu_en, 1'b1);
        chk("nort_pc0", core_pc, 32'h10);
        chk("nort_bp_clr", bp_hit, 2'b00);
        model_run(exp_n, 1'b1);
        @(negedge clk);
        chk("nort_pc1", core_pc, 32'h14);
        settle_check("nort");

        // Both channels on the halt address: halt wins
        bp0 = HALT; bp1 = HALT; en = 2'b11;
        do_start("both_halt");

        // Asynchronous reset in the middle of a run
        en = 2'b00;
        pulse(0);
        for (int i = 0; i < 100; i++) begin
            if (cycle_cnt == 32'd7) break;
            @(negedge clk);
        end
        chk("midrst_reach7", cycle_cnt, 32'd7);
        rst = 1'b1;
        #1;
        chk("midrst_cpu_rst", cpu_rst, 1'b1);
        chk("midrst_cpu_en", cpu_en, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_cnt", cycle_cnt, 32'h0);
        chk("midrst_bp_hit", bp_hit, 2'b00);
        chk("midrst_timeout", timeout, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized breakpoint placement with random cont/step sequences
        for (int it = 0; it < 20; it++) begin
            bp0 = 32'(4 * $urandom_range(0, 20));
            bp1 = 32'(4 * $urandom_range(0, 20));
            en  = 2'($urandom_range(0, 3));
            do_start("rnd");
            for (int a = 0; a < 6; a++) begin
                if (exp_done || exp_to) break;
                if ($urandom_range(0, 1) == 0) do_cont("rnd_cont");
                else                           do_step("rnd_step");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
